// File: rtl/pid_pkg.sv
// pid_pkg: shared defaults and signed saturation helper for the balance PID.
package pid_pkg;
  localparam int PTCH_W_DEF   = 16;
  localparam int ERR_W_DEF    = 10;
  localparam int INT_W_DEF    = 18;
  localparam int OUT_W_DEF    = 12;
  localparam int P_COEFF_DEF  = 9;
  localparam int I_SHIFT_DEF  = 6;
  localparam int D_SHIFT_DEF  = 6;
  localparam int SS_W_DEF     = 27;
  localparam int SS_OUT_W_DEF = 8;
  localparam int SS_SCALE_DEF = 0;
  // Clamp a sign-extended value to the signed range of w bits; callers slice the result.
  function automatic logic signed [63:0] sat(input logic signed [63:0] v, input int w);
    logic signed [63:0] hi, lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    return v > hi ? hi : v < lo ? lo : v;
  endfunction
endpackage

// File: rtl/pid_ctrl_gen_if.sv
// pid_ctrl_gen_if: inertial-sample inputs and control/status outputs of the balance PID.
interface pid_ctrl_gen_if #(
  parameter int PTCH_W   = 16,
  parameter int OUT_W    = 12,
  parameter int SS_OUT_W = 8
);
  logic                       vld;
  logic                       pwr_up;
  logic                       rider_off;
  logic signed [PTCH_W-1:0]   ptch;
  logic signed [PTCH_W-1:0]   ptch_rt;
  logic        [SS_OUT_W-1:0] ss_tmr;
  logic signed [OUT_W-1:0]    PID_cntrl;
  logic                       out_vld;
  logic                       int_sat;
  modport master (
    output vld, pwr_up, rider_off, ptch, ptch_rt,
    input  ss_tmr, PID_cntrl, out_vld, int_sat
  );
  modport slave (
    input  vld, pwr_up, rider_off, ptch, ptch_rt,
    output ss_tmr, PID_cntrl, out_vld, int_sat
  );
endinterface

// File: rtl/soft_start_tmr.sv
// soft_start_tmr: saturating ramp counter, cleared while pwr_up is low.
module soft_start_tmr #(
  parameter int SS_W     = 27,
  parameter int SS_OUT_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                pwr_up_i,
  output logic [SS_OUT_W-1:0] ss_tmr_o
);
  logic [SS_W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = !pwr_up_i ? '0 : &cnt_q[SS_W-1 -: SS_OUT_W] ? cnt_q : cnt_q + 1'b1;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign ss_tmr_o = cnt_q[SS_W-1 -: SS_OUT_W];
endmodule

// File: rtl/pid_ctrl_gen.sv
// pid_ctrl_gen: two-stage pipelined balance PID with clamping integrator and optional soft-start scaling.
module pid_ctrl_gen
  import pid_pkg::*;
#(
  parameter int PTCH_W   = PTCH_W_DEF,
  parameter int ERR_W    = ERR_W_DEF,
  parameter int INT_W    = INT_W_DEF,
  parameter int OUT_W    = OUT_W_DEF,
  parameter int P_COEFF  = P_COEFF_DEF,
  parameter int I_SHIFT  = I_SHIFT_DEF,
  parameter int D_SHIFT  = D_SHIFT_DEF,
  parameter int SS_W     = SS_W_DEF,
  parameter int SS_OUT_W = SS_OUT_W_DEF,
  parameter int SS_SCALE = SS_SCALE_DEF
) (
  input logic           clk,
  input logic           rst_n,
  pid_ctrl_gen_if.slave bus
);
  localparam int PW = ERR_W + 6;
  localparam int DW = PTCH_W - D_SHIFT + 1;
  localparam int IW = INT_W - I_SHIFT;
  localparam int MW = PW > DW ? (PW > IW ? PW : IW) : (DW > IW ? DW : IW);
  localparam int SW = MW + 2;
  localparam logic signed [INT_W-1:0] IMAX = {1'b0, {(INT_W-1){1'b1}}};
  localparam logic signed [INT_W-1:0] IMIN = {1'b1, {(INT_W-1){1'b0}}};
  logic signed [ERR_W-1:0] err_sat;
  logic signed [PW-1:0]    p_d, p_q;
  logic signed [DW-1:0]    d_d, d_q;
  logic signed [IW-1:0]    i_d, i_q;
  logic signed [INT_W-1:0] integ_d, integ_q;
  logic signed [SW-1:0]    sum;
  logic signed [OUT_W-1:0] sat_out, pid_d, pid_q;
  logic [SS_OUT_W-1:0]     ss;
  logic                    sat_d, sat_q, v1_q, ov_q;
  soft_start_tmr #(.SS_W(SS_W), .SS_OUT_W(SS_OUT_W)) u_ss (
    .clk      (clk),
    .rst_n    (rst_n),
    .pwr_up_i (bus.pwr_up),
    .ss_tmr_o (ss)
  );
  // I term is taken from the post-update integrator so rider_off zeroes it for the same sample.
  always_comb begin
    err_sat = ERR_W'(sat(64'(bus.ptch), ERR_W));
    p_d     = PW'(err_sat) * PW'(P_COEFF);
    d_d     = -(DW'(bus.ptch_rt >>> D_SHIFT));
    integ_d = bus.rider_off ? '0 :
              bus.vld ? INT_W'(sat(64'(integ_q) + 64'(err_sat), INT_W)) : integ_q;
    sat_d   = integ_d == IMAX || integ_d == IMIN;
    i_d     = IW'(integ_d >>> I_SHIFT);
    sum     = SW'(p_q) + SW'(i_q) + SW'(d_q);
    sat_out = OUT_W'(sat(64'(sum), OUT_W));
  end
  if (SS_SCALE != 0) begin : g_scale
    localparam int MUL_W = OUT_W + SS_OUT_W + 1;
    logic signed [MUL_W-1:0] prod;
    assign prod  = MUL_W'(sat_out) * MUL_W'($signed({1'b0, ss}));
    assign pid_d = OUT_W'(prod >>> SS_OUT_W);
  end else begin : g_raw
    assign pid_d = sat_out;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      p_q     <= '0;
      d_q     <= '0;
      i_q     <= '0;
      integ_q <= '0;
      sat_q   <= 1'b0;
      v1_q    <= 1'b0;
      ov_q    <= 1'b0;
      pid_q   <= '0;
    end else begin
      integ_q <= integ_d;
      sat_q   <= sat_d;
      v1_q    <= bus.vld;
      ov_q    <= v1_q;
      if (bus.vld) begin
        p_q <= p_d;
        d_q <= d_d;
        i_q <= i_d;
      end
      if (v1_q) pid_q <= pid_d;
    end
  assign bus.PID_cntrl = pid_q;
  assign bus.out_vld   = ov_q;
  assign bus.int_sat   = sat_q;
  assign bus.ss_tmr    = ss;
endmodule

// File: tb/tb_pid_ctrl_gen.sv
// tb_pid_ctrl_gen: scenario tests plus randomized streaming against an arithmetic PID model.
module tb_pid_ctrl_gen;
  logic clk, rst_n;
  int checks = 0;
  int errors = 0;
  int m_integ;
  pid_ctrl_gen_if ia ();
  pid_ctrl_gen_if ib ();
  pid_ctrl_gen dut_a (.clk(clk), .rst_n(rst_n), .bus(ia));
  pid_ctrl_gen #(.SS_SCALE(1), .SS_W(12)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ib));
  always #5 clk = ~clk;
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, time %0t required < 2000000", $time);
    $fatal(1);
  end
  function automatic int clip(input int v, input int w);
    int hi, lo;
    hi = (1 <<< (w - 1)) - 1;
    lo = -hi - 1;
    return v > hi ? hi : v < lo ? lo : v;
  endfunction
  function automatic int model_step(input int p, input int rt, input bit v, input bit ro,
                                    input int ss, input bit scale, inout int integ);
    int e, s;
    e = clip(p, 10);
    if (ro) integ = 0;
    else if (v) integ = clip(integ + e, 18);
    s = clip(9 * e + (integ >>> 6) - (rt >>> 6), 12);
    return scale ? (s * ss) >>> 8 : s;
  endfunction
  task automatic send_a(input int p, input int rt, input bit ro);
    @(negedge clk);
    ia.vld = 1; ia.ptch = 16'(p); ia.ptch_rt = 16'(rt); ia.rider_off = ro;
    @(negedge clk);
    ia.vld = 0; ia.rider_off = 0;
  endtask
  task automatic send_b(input int p);
    @(negedge clk);
    ib.vld = 1; ib.ptch = 16'(p);
    @(negedge clk);
    ib.vld = 0;
  endtask
  task automatic test_reset;
    rst_n = 0;
    ib.pwr_up = 1;
    repeat (3) @(negedge clk);
    checks++;
    if (ia.PID_cntrl !== 0 || ia.out_vld !== 0 || ia.int_sat !== 0 || ia.ss_tmr !== 0 || ib.ss_tmr !== 0)
      begin errors++; $display("FAIL reset: PID=%0d vld=%b sat=%b ss=%0d/%0d required all 0",
        ia.PID_cntrl, ia.out_vld, ia.int_sat, ia.ss_tmr, ib.ss_tmr); end
    ib.pwr_up = 0;
    rst_n = 1;
  endtask
  task automatic test_single;
    send_a(16, 0, 0);
    checks++;
    if (ia.out_vld !== 0) begin errors++; $display("FAIL latency_early: out_vld=%b required 0", ia.out_vld); end
    @(negedge clk);
    checks++;
    if (ia.out_vld !== 1 || ia.PID_cntrl !== 12'sd144)
      begin errors++; $display("FAIL single: vld=%b PID=%0d required 1/144", ia.out_vld, ia.PID_cntrl); end
    @(negedge clk);
    checks++;
    if (ia.out_vld !== 0 || ia.PID_cntrl !== 12'sd144)
      begin errors++; $display("FAIL hold: vld=%b PID=%0d required 0/144", ia.out_vld, ia.PID_cntrl); end
  endtask
  task automatic test_p_sat;
    send_a(32'h7FFF, 0, 0);
    @(negedge clk);
    checks++;
    if (ia.out_vld !== 1 || ia.PID_cntrl !== 12'h7FF)
      begin errors++; $display("FAIL p_sat: vld=%b PID=%0d required 1/2047", ia.out_vld, ia.PID_cntrl); end
  endtask
  task automatic test_clamp;
    for (int k = 0; k < 302; k++) begin
      @(negedge clk);
      if (k >= 2) begin
        checks++;
        if (ia.out_vld !== 1 || ia.PID_cntrl !== 12'h800)
          begin errors++; $display("FAIL clamp[%0d]: vld=%b PID=%0d required 1/-2048", k, ia.out_vld, ia.PID_cntrl); end
      end
      ia.vld = k < 300; ia.ptch = -16'sd512; ia.ptch_rt = 0;
    end
    @(negedge clk);
    checks++;
    if (ia.int_sat !== 1 || ia.out_vld !== 0)
      begin errors++; $display("FAIL clamp_sat: int_sat=%b vld=%b required 1/0", ia.int_sat, ia.out_vld); end
  endtask
  task automatic test_rider_off;
    send_a(0, 0, 1);
    checks++;
    if (ia.int_sat !== 0) begin errors++; $display("FAIL rider_sat: int_sat=%b required 0", ia.int_sat); end
    @(negedge clk);
    checks++;
    if (ia.out_vld !== 1 || ia.PID_cntrl !== 0)
      begin errors++; $display("FAIL rider_out: vld=%b PID=%0d required 1/0", ia.out_vld, ia.PID_cntrl); end
  endtask
  task automatic test_d_term;
    send_a(0, 1024, 0);
    @(negedge clk);
    checks++;
    if (ia.out_vld !== 1 || ia.PID_cntrl !== 12'hFF0)
      begin errors++; $display("FAIL d_term: vld=%b PID=%0d required 1/-16", ia.out_vld, ia.PID_cntrl); end
  endtask
  task automatic test_back_to_back;
    bit ev[2];
    int ep[2];
    int last = 0;
    bit msat = 0;
    @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    m_integ = 0;
    ev = '{0, 0};
    for (int k = 0; k < 600; k++) begin
      logic signed [15:0] rp, rr;
      bit v, ro;
      int e;
      @(negedge clk);
      checks++;
      if (ia.out_vld !== ev[1] || ia.PID_cntrl !== 12'(ev[1] ? ep[1] : last) || ia.int_sat !== msat)
        begin errors++; $display("FAIL b2b[%0d]: vld=%b PID=%0d sat=%b required %b/%0d/%b",
          k, ia.out_vld, ia.PID_cntrl, ia.int_sat, ev[1], ev[1] ? ep[1] : last, msat); end
      if (ev[1]) last = ep[1];
      rp = $urandom_range(0, 3) == 0 ? 16'($urandom) : 16'($urandom_range(0, 1400) - 700);
      rr = $urandom_range(0, 1) == 0 ? 16'($urandom) : 16'($urandom_range(0, 4000) - 2000);
      v  = $urandom_range(0, 3) != 0;
      ro = $urandom_range(0, 24) == 0;
      ia.vld = v; ia.ptch = rp; ia.ptch_rt = rr; ia.rider_off = ro;
      e = model_step(int'(rp), int'(rr), v, ro, 0, 0, m_integ);
      msat = m_integ == 131071 || m_integ == -131072;
      ev[1] = ev[0]; ep[1] = ep[0];
      ev[0] = v; ep[0] = e;
    end
    @(negedge clk);
    ia.vld = 0; ia.rider_off = 0;
  endtask
  task automatic test_reset_mid;
    @(negedge clk);
    ia.vld = 1; ia.ptch = 16'sd100; ia.ptch_rt = 0;
    @(negedge clk);
    ia.vld = 0;
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if (ia.out_vld !== 0 || ia.PID_cntrl !== 0)
        begin errors++; $display("FAIL reset_mid[%0d]: vld=%b PID=%0d required 0/0", k, ia.out_vld, ia.PID_cntrl); end
    end
  endtask
  task automatic test_soft_start;
    int bint = 0;
    int e;
    ib.pwr_up = 0;
    e = model_step(16, 0, 1, 0, 0, 1, bint);
    send_b(16);
    @(negedge clk);
    checks++;
    if (ib.out_vld !== 1 || ib.PID_cntrl !== 12'(e) || ib.ss_tmr !== 0)
      begin errors++; $display("FAIL ss_off: vld=%b PID=%0d ss=%0d required 1/%0d/0", ib.out_vld, ib.PID_cntrl, ib.ss_tmr, e); end
    ib.pwr_up = 1;
    repeat (2000) @(negedge clk);
    checks++;
    if (ib.ss_tmr !== 8'd125) begin errors++; $display("FAIL ss_ramp: ss=%0d required 125", ib.ss_tmr); end
    repeat (2080) @(negedge clk);
    checks++;
    if (ib.ss_tmr !== 8'd255) begin errors++; $display("FAIL ss_top: ss=%0d required 255", ib.ss_tmr); end
    repeat (300) @(negedge clk);
    checks++;
    if (ib.ss_tmr !== 8'd255) begin errors++; $display("FAIL ss_hold: ss=%0d required 255", ib.ss_tmr); end
    send_b(16);
    @(negedge clk);
    checks++;
    if (ib.out_vld !== 1 || ib.PID_cntrl !== 12'sd143)
      begin errors++; $display("FAIL ss_pos: vld=%b PID=%0d required 1/143", ib.out_vld, ib.PID_cntrl); end
    send_b(-16);
    @(negedge clk);
    checks++;
    if (ib.out_vld !== 1 || ib.PID_cntrl !== -12'sd144)
      begin errors++; $display("FAIL ss_neg: vld=%b PID=%0d required 1/-144", ib.out_vld, ib.PID_cntrl); end
    ib.pwr_up = 0;
    @(negedge clk);
    checks++;
    if (ib.ss_tmr !== 0) begin errors++; $display("FAIL ss_clear: ss=%0d required 0", ib.ss_tmr); end
  endtask
  initial begin
    clk = 0;
    rst_n = 0;
    ia.vld = 0; ia.pwr_up = 0; ia.rider_off = 0; ia.ptch = 0; ia.ptch_rt = 0;
    ib.vld = 0; ib.pwr_up = 0; ib.rider_off = 0; ib.ptch = 0; ib.ptch_rt = 0;
    test_reset;
    test_single;
    test_p_sat;
    test_clamp;
    test_rider_off;
    test_d_term;
    test_back_to_back;
    test_reset_mid;
    test_soft_start;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
